// File: rtl/scalar_mult_ctrl.sv
// scalar_mult_ctrl
// Computes Q = k*P by double-and-add, scanning k MSB-first. It drives a single
// shared point_add unit and holds the extended-coordinate accumulator Q.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start, scalar, px..pt    request; k and base point P latched on accept
//   busy, done, qx..qt       handshake and result (result held until next done)
//   pa_start                 one-cycle launch pulse to point_add
//   pa_x1..pa_t1             operand 1 (always the accumulator Q)
//   pa_x2..pa_t2             operand 2 (Q when doubling, P when adding)
//   pa_done, pa_x3..pa_t3    point_add completion and result
module scalar_mult_ctrl #(
  parameter int NBITS = 253,
  parameter int W     = 257
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NBITS-1:0] scalar,
  input  logic [W-1:0]     px,
  input  logic [W-1:0]     py,
  input  logic [W-1:0]     pz,
  input  logic [W-1:0]     pt,
  output logic             busy,
  output logic             done,
  output logic [W-1:0]     qx,
  output logic [W-1:0]     qy,
  output logic [W-1:0]     qz,
  output logic [W-1:0]     qt,
  output logic             pa_start,
  output logic [W-1:0]     pa_x1,
  output logic [W-1:0]     pa_y1,
  output logic [W-1:0]     pa_z1,
  output logic [W-1:0]     pa_t1,
  output logic [W-1:0]     pa_x2,
  output logic [W-1:0]     pa_y2,
  output logic [W-1:0]     pa_z2,
  output logic [W-1:0]     pa_t2,
  input  logic             pa_done,
  input  logic [W-1:0]     pa_x3,
  input  logic [W-1:0]     pa_y3,
  input  logic [W-1:0]     pa_z3,
  input  logic [W-1:0]     pa_t3
);

  localparam int IW = (NBITS > 1) ? $clog2(NBITS) : 1;

  typedef enum logic [2:0] {
    IDLE, DBL_ISSUE, DBL_WAIT, ADD_ISSUE, ADD_WAIT, NEXT, FINISH
  } state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic [NBITS-1:0] k;
  logic [W-1:0]     bx, by, bz, bt;   // latched base point P
  logic [W-1:0]     ax, ay, az, at;   // accumulator Q
  logic             is_add;           // selects P as operand 2

  // Operands come straight from registers, so they are stable for the whole
  // ISSUE..pa_done window; the accumulator only moves on the pa_done cycle.
  assign pa_x1 = ax;
  assign pa_y1 = ay;
  assign pa_z1 = az;
  assign pa_t1 = at;
  assign pa_x2 = is_add ? bx : ax;
  assign pa_y2 = is_add ? by : ay;
  assign pa_z2 = is_add ? bz : az;
  assign pa_t2 = is_add ? bt : at;

  // pa_start and done are registered: they are raised on the transition into
  // the ISSUE/FINISH state so they are high exactly during that state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      k        <= '0;
      bx       <= '0;
      by       <= '0;
      bz       <= '0;
      bt       <= '0;
      ax       <= '0;
      ay       <= '0;
      az       <= '0;
      at       <= '0;
      is_add   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pa_start <= 1'b0;
      qx       <= '0;
      qy       <= '0;
      qz       <= '0;
      qt       <= '0;
    end else begin
      pa_start <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            k        <= scalar;
            bx       <= px;
            by       <= py;
            bz       <= pz;
            bt       <= pt;
            // neutral element (0,1,1,0)
            ax       <= '0;
            ay       <= W'(1);
            az       <= W'(1);
            at       <= '0;
            idx      <= IW'(NBITS - 1);
            is_add   <= 1'b0;
            busy     <= 1'b1;
            pa_start <= 1'b1;
            state    <= DBL_ISSUE;
          end
        end
        DBL_ISSUE: state <= DBL_WAIT;
        DBL_WAIT: begin
          if (pa_done) begin
            ax <= pa_x3;
            ay <= pa_y3;
            az <= pa_z3;
            at <= pa_t3;
            if (k[idx]) begin
              is_add   <= 1'b1;
              pa_start <= 1'b1;
              state    <= ADD_ISSUE;
            end else begin
              state <= NEXT;
            end
          end
        end
        ADD_ISSUE: state <= ADD_WAIT;
        ADD_WAIT: begin
          if (pa_done) begin
            ax    <= pa_x3;
            ay    <= pa_y3;
            az    <= pa_z3;
            at    <= pa_t3;
            state <= NEXT;
          end
        end
        NEXT: begin
          if (idx == '0) begin
            qx    <= ax;
            qy    <= ay;
            qz    <= az;
            qt    <= at;
            done  <= 1'b1;
            state <= FINISH;
          end else begin
            idx      <= idx - 1'b1;
            is_add   <= 1'b0;
            pa_start <= 1'b1;
            state    <= DBL_ISSUE;
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/scalar_mult_ctrl.md
Name: scalar_mult_ctrl

Overview:
Sequencer that computes the scalar multiple Q = k·P on the Ed25519 curve by driving one shared point_add instance. It scans k MSB-first: for each bit it does Q = Q+Q, and when the bit is 1 it also does Q = Q+P. It owns the extended-coordinate accumulator (X,Y,Z,T), latches the base point and scalar, and exposes a start/busy/done handshake to the signing/verification top level.

Parameters:
NBITS, 253, scalar width in bits (bench may override to small values)
W, 257, coordinate width; matches point_add operand width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  request; sampled only in IDLE
scalar  in  NBITS  k; latched when start is accepted
px, py, pz, pt  in  W each  base point P; latched when start is accepted
busy  out  1  high from accept until the done cycle, inclusive
done  out  1  one-cycle pulse; result valid
qx, qy, qz, qt  out  W each  result; hold until the next done
pa_start  out  1  one-cycle start pulse to point_add
pa_x1, pa_y1, pa_z1, pa_t1  out  W each  point_add operand 1 (always Q)
pa_x2, pa_y2, pa_z2, pa_t2  out  W each  point_add operand 2 (Q when doubling, P when adding)
pa_done  in  1  point_add completion
pa_x3, pa_y3, pa_z3, pa_t3  in  W each  point_add result

Behaviour:
- Reset (async, any state): state=IDLE, busy=0, done=0, pa_start=0, qx/qy/qz/qt=0, accumulator=0, bit index=0.
- States: IDLE, DBL_ISSUE, DBL_WAIT, ADD_ISSUE, ADD_WAIT, NEXT, FINISH.
- IDLE: on start=1:
  - latch scalar and P;
  - set accumulator to the neutral point (0,1,1,0);
  - set index i=NBITS-1, busy=1;
  - go to DBL_ISSUE.
- DBL_ISSUE: pa_start=1 for this cycle only; operand 2 = Q; go to DBL_WAIT.
- DBL_WAIT: wait for pa_done. In the cycle pa_done=1, capture pa_x3..pa_t3 into the accumulator. Then go to ADD_ISSUE if scalar[i]=1, else NEXT.
- ADD_ISSUE: same as DBL_ISSUE, but operand 2 = latched P; go to ADD_WAIT.
- ADD_WAIT: same as DBL_WAIT; then go to NEXT.
- NEXT: if i==0 go to FINISH; else decrement i and go to DBL_ISSUE.
- FINISH: copy the accumulator to qx..qt; done=1 and busy=1 this cycle. Next cycle: IDLE, busy=0, done=0.
- pa_x1..pa_t2 stay stable from the ISSUE cycle through the cycle pa_done is seen.
- No leading-zero skip: exactly NBITS doublings, plus one addition per set bit.
- Latency: point_add latency Lp ≥ 1 cycles, measured from the pa_start cycle to the pa_done cycle.
  - Each operation costs Lp+1 cycles; NEXT costs 1 cycle.
  - With start accepted in cycle 0, done occurs in cycle 1 + Σ_i[(Lp+1)(1+k_i) + 1].
- pa_done is ignored in IDLE, ISSUE, NEXT and FINISH states. A single pa_done pulse completes exactly one operation.
- start is ignored while busy, including start=1 in the FINISH cycle. start held high in IDLE retriggers on the cycle after done.
- No arithmetic in this block: results are passed through unmodified at width W.
- Reset mid-operation aborts the operation; q outputs clear to 0. point_add has no reset, so the integrating top must hold start low until any outstanding pa_done has passed.

Test Plan:
- Stub point_add model: x3=x1+x2, y3=y1, z3=z1, t3=t1, Lp=3. Base P=(1,1,1,0), NBITS=4.
- scalar=5 with the stub -> exactly 6 pa_start pulses; done in cycle 29 after the start cycle; qx=5, qy=1, qz=1, qt=0; busy high for cycles 1..29.
- scalar=0 -> 4 pulses, all with operand 2 = Q; qx=0, qy=1, qz=1, qt=0. scalar=4'hF -> 8 pulses; qx=15.
- Spurious pa_done in IDLE, plus start pulsed during busy -> no state change; exactly one done; result unchanged.
- rst asserted during ADD_WAIT of a scalar=5 run -> same cycle: busy=0, pa_start=0, qx..qt=0. A fresh start with scalar=3 then yields qx=3.
- NBITS=253, real point_add, P = Ed25519 base point, k=1 -> (qx·qz⁻¹, qy·qz⁻¹) mod q equals the base point's affine coordinates.
